// File: rtl/tinyqv_peri_bus_arbiter.sv
// tinyqv_peri_bus_arbiter: shares the TinyQV peripheral bus between two masters with a read timeout watchdog
module tinyqv_peri_bus_arbiter #(
    parameter bit          ROUND_ROBIN    = 1'b1,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hFFFF_FFFF,
    localparam int         CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [21:0] m_addr,
    input  logic [63:0] m_wdata,
    input  logic [3:0]  m_write_n,
    input  logic [3:0]  m_read_n,
    input  logic [1:0]  m_read_complete,
    output logic [31:0] m_rdata,
    output logic [1:0]  m_ready,
    output logic [10:0] peri_addr,
    output logic [31:0] peri_wdata,
    output logic [1:0]  peri_write_n,
    output logic [1:0]  peri_read_n,
    output logic        peri_read_complete,
    input  logic [31:0] peri_rdata,
    input  logic        peri_ready,
    output logic [1:0]  grant,
    output logic        timeout_pulse
);
    typedef enum logic [1:0] {IDLE, XFER, WAIT_DONE, RELEASE} state_t;
    localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYCLES);
    state_t           state, state_nx;
    logic             g, g_nx, last, timed_out, rdy;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       req, g_write_n, g_read_n;
    logic [10:0]      g_addr;
    logic [31:0]      g_wdata;
    logic             g_req, g_wr, g_rc;
    assign req[0]    = (m_read_n[1:0] != 2'b11) || (m_write_n[1:0] != 2'b11);
    assign req[1]    = (m_read_n[3:2] != 2'b11) || (m_write_n[3:2] != 2'b11);
    assign g_addr    = g ? m_addr[21:11] : m_addr[10:0];
    assign g_wdata   = g ? m_wdata[63:32] : m_wdata[31:0];
    assign g_write_n = g ? m_write_n[3:2] : m_write_n[1:0];
    assign g_read_n  = g ? m_read_n[3:2] : m_read_n[1:0];
    assign g_rc      = g ? m_read_complete[1] : m_read_complete[0];
    assign g_req     = g ? req[1] : req[0];
    assign g_wr      = g_write_n != 2'b11;
    // State, owner, fairness bit, read watchdog counter and timeout memory
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            g         <= 1'b0;
            last      <= 1'b1;
            cnt       <= '0;
            timed_out <= 1'b0;
        end else begin
            state     <= state_nx;
            g         <= g_nx;
            last      <= (state == RELEASE) ? g : last;
            cnt       <= (state == XFER && !g_wr && cnt != TO_MAX) ? cnt + 1'b1 : '0;
            timed_out <= timeout_pulse || (state == WAIT_DONE && timed_out);
        end
    end
    // Next-state, bus steering and master handshakes
    always_comb begin
        state_nx           = state;
        g_nx               = g;
        peri_addr          = '0;
        peri_wdata         = '0;
        peri_write_n       = 2'b11;
        peri_read_n        = 2'b11;
        peri_read_complete = 1'b0;
        m_rdata            = peri_rdata;
        grant              = 2'b00;
        timeout_pulse      = 1'b0;
        rdy                = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    g_nx     = &req ? (ROUND_ROBIN ? !last : 1'b0) : req[1];
                    state_nx = XFER;
                end
            end
            XFER: begin
                grant        = g ? 2'b10 : 2'b01;
                peri_addr    = g_addr;
                peri_wdata   = g_wdata;
                peri_write_n = g_write_n;
                peri_read_n  = g_read_n;
                if (!g_req) begin
                    state_nx = RELEASE;
                end else if (g_wr) begin
                    rdy      = peri_ready;
                    state_nx = peri_ready ? RELEASE : XFER;
                end else if (peri_ready) begin
                    rdy      = 1'b1;
                    state_nx = WAIT_DONE;
                end else if (cnt == TO_MAX) begin
                    rdy           = 1'b1;
                    m_rdata       = TIMEOUT_DATA;
                    timeout_pulse = 1'b1;
                    state_nx      = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                grant       = g ? 2'b10 : 2'b01;
                peri_addr   = g_addr;
                peri_read_n = timed_out ? 2'b11 : g_read_n;
                if (!g_req) begin
                    state_nx = RELEASE;
                end else begin
                    rdy                = !timed_out && peri_ready;
                    peri_read_complete = g_rc;
                    state_nx           = g_rc ? RELEASE : WAIT_DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
        m_ready = {rdy && g, rdy && !g};
    end
endmodule
